i2c_byte_ctrl: RTL
==================

# i2c_byte_ctrl

Byte-level I2C master for the EEPROM byte read/write path. It sits directly downstream of the read/write request generator. It consumes `wr_en`, `rd_en`, `i2c_start`, `byte_addr` and `wr_data`, and runs one complete single-byte write or random-read transaction on the open-drain SCL/SDA pair. It returns `i2c_clk` for the upstream stage, plus `i2c_end`, `rd_data` and `ack_err`.

## Interface
- `DEVICE_ADDR`, default 7'b1010_011: 7-bit slave address.
- `SYS_CLK_FREQ`, default 50_000_000: `clk` frequency in Hz.
- `SCL_FREQ`, default 250_000: SCL frequency in Hz. `SYS_CLK_FREQ/(SCL_FREQ*8)` must be an integer ≥ 2.
- `clk  in  1`: system clock. All logic is on `clk` rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `wr_en  in  1`: selects a write transaction. Level, held until `i2c_end`.
- `rd_en  in  1`: selects a read transaction. Level, held until `i2c_end`.
- `i2c_start  in  1`: transaction request. High for at least one `i2c_clk` period.
- `addr_num  in  1`: 1 = 16-bit word address, 0 = 8-bit word address (`byte_addr[7:0]` only).
- `byte_addr  in  16`: EEPROM word address.
- `wr_data  in  8`: byte to write.
- `i2c_clk  out  1`: registered divided clock at 4×`SCL_FREQ` (1 MHz by default), 50 % duty. Drives the upstream stage.
- `i2c_end  out  1`: single-`clk` pulse at transaction completion.
- `rd_data  out  8`: last byte read. Holds its value until the next read completes.
- `ack_err  out  1`: single-`clk` pulse together with `i2c_end` when the slave NACKed.
- `i2c_scl  out  1`: SCL.
- `i2c_sda  inout  1`: SDA, open-drain. Either driven 0 or left at 1'bz.

## Operation
- **Divider.** `cnt_clk` counts 0..`CNT_MAX`, where `CNT_MAX = SYS_CLK_FREQ/(SCL_FREQ*8)-1`.
  - `i2c_clk` toggles at wrap.
  - `tick` is a 1-`clk` pulse on the wrap that takes `i2c_clk` 0→1. All FSM activity is gated by `tick`.
- **Bit timing.** Every bit is 4 ticks, tracked by quarter counter `q` (0..3).
  - `q`=0: SCL low, SDA updated.
  - `q`=1 and `q`=2: SCL high.
  - `q`=3: SCL low.
  - Slave data and ACK are sampled at `q`=2.
- **START.** SCL: 0, 1, 1, 0. SDA: 1, 1, 0, 0.
- **STOP.** SCL: 0, 1, 1, 1. SDA: 0, 0, 0, 1.
- **FSM states:**
  - IDLE → START_1 on `tick` with `i2c_start`=1 and (`wr_en` | `rd_en`). Otherwise stay in IDLE.
  - START_1 → SEND_D_ADDR. Sends {`DEVICE_ADDR`, 0}, MSB first, 8 bits.
  - ACK_1 → SEND_B_ADDR_H if `addr_num`=1, else SEND_B_ADDR_L.
  - SEND_B_ADDR_H → ACK_2 → SEND_B_ADDR_L → ACK_3.
  - ACK_3 → WR_DATA if write, START_2 if read.
  - WR_DATA → ACK_4 → STOP.
  - START_2 → SEND_RD_ADDR. Sends {`DEVICE_ADDR`, 1}.
  - SEND_RD_ADDR → ACK_5 → RD_DATA (8 bits, shifted in MSB first) → N_ACK (master releases SDA for 1 bit) → STOP → IDLE.
- **Write/read priority.** `wr_en` has priority if both `wr_en` and `rd_en` are high. The choice is latched at START_1.
- **Input latching.** `byte_addr`, `wr_data` and `addr_num` are latched at START_1.
- **SDA release.** SDA is released during every ACK state, RD_DATA and N_ACK.
- **Slave NACK.** If SDA=1 at `q`=2 of any ACK state, the FSM goes to STOP after that bit. `ack_err` then pulses together with `i2c_end`.
- **Bit counter.** A 3-bit counter, cleared at each byte boundary.

## Timing
- **Reset values:**
  - `i2c_clk`=0, `i2c_end`=0, `ack_err`=0, `rd_data`=8'h00.
  - `i2c_scl`=1, SDA released.
  - FSM = IDLE, `cnt_clk`=0, `q`=0.
- **Reset mid-transaction.** SCL=1 and SDA released immediately on `rst_n` low. No STOP is issued.
- **Completion.** `i2c_end` is high for the one `clk` cycle on which the STOP `q`=3 tick occurs. `rd_data` is already valid in that cycle.
- **Latency, start tick to `i2c_end` (defaults, 200 `clk` per bit):**
  - 16-bit write: 38 bits = 7600 `clk`.
  - 8-bit write: 29 bits = 5800 `clk`.
  - 16-bit read: 48 bits = 9600 `clk`.
  - 8-bit read: 39 bits = 7800 `clk`.
- **Busy behaviour.** `i2c_start` is ignored outside IDLE. `i2c_start` with neither `wr_en` nor `rd_en` high is ignored.
- **Back-to-back.** A new transaction may begin on the first tick after returning to IDLE.

## Test plan
- **Reset.** Hold `rst_n`=0 for 10 `clk` → SCL=1, SDA=Z, all outputs 0. After release, `i2c_clk` period is 50 `clk`.
- **16-bit write.** `wr_en`=1, `addr_num`=1, `byte_addr`=16'h0123, `wr_data`=8'h36, slave model ACKs → bus carries START, A6, 01, 23, 36, STOP. `i2c_end` arrives 7600 `clk` after the start tick. `ack_err`=0.
- **16-bit read.** `rd_en`=1, addr 16'h0123, slave returns 8'h36 → bus carries A6, 01, 23, repeated START, A7, master NACK, STOP. `rd_data`=8'h36 at `i2c_end`, 9600 `clk` after the start tick.
- **8-bit address.** Write with `addr_num`=0, `byte_addr`=16'h0045 → high address byte skipped. 5800 `clk` latency.
- **Slave NACK.** Slave NACKs the device address → STOP follows ACK_1. `i2c_end` and `ack_err` pulse together. FSM returns to IDLE.
- **Simultaneous and mid-transaction events.** `wr_en`=`rd_en`=1 → write performed. Then `rst_n` asserted mid-RD_DATA → bus released at once. A subsequent read completes normally.

Source files
------------

// File: rtl/i2c_byte_ctrl.sv
// Byte-level I2C master: one single-byte write or random read per request.
// Each SCL bit is four ticks of the divided clock; SDA is open-drain.
module i2c_byte_ctrl #(
  parameter logic [6:0] DEVICE_ADDR  = 7'b1010_011,
  parameter int         SYS_CLK_FREQ = 50_000_000,
  parameter int         SCL_FREQ     = 250_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic        i2c_start,
  input  logic        addr_num,
  input  logic [15:0] byte_addr,
  input  logic [7:0]  wr_data,
  output logic        i2c_clk,
  output logic        i2c_end,
  output logic [7:0]  rd_data,
  output logic        ack_err,
  output logic        i2c_scl,
  inout  wire         i2c_sda
);

  localparam logic [15:0] CNT_MAX = 16'(SYS_CLK_FREQ / (SCL_FREQ * 8) - 1);

  localparam logic [3:0] IDLE          = 4'd0;
  localparam logic [3:0] START_1       = 4'd1;
  localparam logic [3:0] SEND_D_ADDR   = 4'd2;
  localparam logic [3:0] ACK_1         = 4'd3;
  localparam logic [3:0] SEND_B_ADDR_H = 4'd4;
  localparam logic [3:0] ACK_2         = 4'd5;
  localparam logic [3:0] SEND_B_ADDR_L = 4'd6;
  localparam logic [3:0] ACK_3         = 4'd7;
  localparam logic [3:0] WR_DATA       = 4'd8;
  localparam logic [3:0] ACK_4         = 4'd9;
  localparam logic [3:0] START_2       = 4'd10;
  localparam logic [3:0] SEND_RD_ADDR  = 4'd11;
  localparam logic [3:0] ACK_5         = 4'd12;
  localparam logic [3:0] RD_DATA       = 4'd13;
  localparam logic [3:0] N_ACK         = 4'd14;
  localparam logic [3:0] STOP          = 4'd15;

  logic [15:0] cnt_clk_r;
  logic [3:0]  state_r, state_n_s;
  logic [1:0]  q_r;
  logic [2:0]  bit_cnt_r, bit_idx_s;
  logic [15:0] addr_r;
  logic [7:0]  data_r, rd_shift_r, tx_byte_s;
  logic        addr16_r, is_wr_r, nack_r;
  logic        scl_r, sda_low_r, scl_s, sda_low_s;
  logic        tick_s, done_s, byte_end_s, mid_s, is_ack_s, is_data_s, sda_in_s;

  assign tick_s     = (cnt_clk_r == CNT_MAX) && !i2c_clk;
  assign done_s     = tick_s && (state_r == STOP) && (q_r == 2'd3);
  assign byte_end_s = (bit_cnt_r == 3'd7);
  assign bit_idx_s  = 3'd7 - bit_cnt_r;
  assign mid_s      = (q_r == 2'd1) || (q_r == 2'd2);
  assign sda_in_s   = i2c_sda;
  assign i2c_scl    = scl_r;
  assign i2c_sda    = sda_low_r ? 1'b0 : 1'bz;

  // Divider producing i2c_clk and the FSM tick on its rising wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_clk_r <= 16'd0;
      i2c_clk   <= 1'b0;
    end else if (cnt_clk_r == CNT_MAX) begin
      cnt_clk_r <= 16'd0;
      i2c_clk   <= ~i2c_clk;
    end else begin
      cnt_clk_r <= cnt_clk_r + 16'd1;
    end
  end

  // State classification used for bit counting and ACK sampling
  always_comb begin
    is_ack_s  = 1'b0;
    is_data_s = 1'b0;
    case (state_r)
      ACK_1, ACK_2, ACK_3, ACK_4, ACK_5:                         is_ack_s  = 1'b1;
      SEND_D_ADDR, SEND_B_ADDR_H, SEND_B_ADDR_L, WR_DATA,
      SEND_RD_ADDR, RD_DATA:                                     is_data_s = 1'b1;
      default: begin
        is_ack_s  = 1'b0;
        is_data_s = 1'b0;
      end
    endcase
  end

  // Next state, taken at the end of each bit (or any tick while idle)
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      IDLE:          state_n_s = (i2c_start && (wr_en || rd_en)) ? START_1 : IDLE;
      START_1:       state_n_s = SEND_D_ADDR;
      SEND_D_ADDR:   state_n_s = byte_end_s ? ACK_1 : SEND_D_ADDR;
      ACK_1:         state_n_s = nack_r ? STOP : (addr16_r ? SEND_B_ADDR_H : SEND_B_ADDR_L);
      SEND_B_ADDR_H: state_n_s = byte_end_s ? ACK_2 : SEND_B_ADDR_H;
      ACK_2:         state_n_s = nack_r ? STOP : SEND_B_ADDR_L;
      SEND_B_ADDR_L: state_n_s = byte_end_s ? ACK_3 : SEND_B_ADDR_L;
      ACK_3:         state_n_s = nack_r ? STOP : (is_wr_r ? WR_DATA : START_2);
      WR_DATA:       state_n_s = byte_end_s ? ACK_4 : WR_DATA;
      ACK_4:         state_n_s = STOP;
      START_2:       state_n_s = SEND_RD_ADDR;
      SEND_RD_ADDR:  state_n_s = byte_end_s ? ACK_5 : SEND_RD_ADDR;
      ACK_5:         state_n_s = nack_r ? STOP : RD_DATA;
      RD_DATA:       state_n_s = byte_end_s ? N_ACK : RD_DATA;
      N_ACK:         state_n_s = STOP;
      STOP:          state_n_s = IDLE;
      default:       state_n_s = IDLE;
    endcase
  end

  // Byte currently being shifted out by the master
  always_comb begin
    case (state_r)
      SEND_D_ADDR:   tx_byte_s = {DEVICE_ADDR, 1'b0};
      SEND_B_ADDR_H: tx_byte_s = addr_r[15:8];
      SEND_B_ADDR_L: tx_byte_s = addr_r[7:0];
      WR_DATA:       tx_byte_s = data_r;
      SEND_RD_ADDR:  tx_byte_s = {DEVICE_ADDR, 1'b1};
      default:       tx_byte_s = 8'hFF;
    endcase
  end

  // SCL/SDA pattern per quarter; ACK, read and master-NACK bits release SDA
  always_comb begin
    scl_s     = 1'b1;
    sda_low_s = 1'b0;
    case (state_r)
      IDLE: begin
        scl_s     = 1'b1;
        sda_low_s = 1'b0;
      end
      START_1, START_2: begin
        scl_s     = mid_s;
        sda_low_s = q_r[1];
      end
      STOP: begin
        scl_s     = (q_r != 2'd0);
        sda_low_s = (q_r != 2'd3);
      end
      SEND_D_ADDR, SEND_B_ADDR_H, SEND_B_ADDR_L, WR_DATA, SEND_RD_ADDR: begin
        scl_s     = mid_s;
        sda_low_s = ~tx_byte_s[bit_idx_s];
      end
      default: begin
        scl_s     = mid_s;
        sda_low_s = 1'b0;
      end
    endcase
  end

  // FSM: one quarter-bit per tick, state changes only at bit boundaries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      q_r        <= 2'd0;
      bit_cnt_r  <= 3'd0;
      addr_r     <= 16'd0;
      data_r     <= 8'd0;
      addr16_r   <= 1'b0;
      is_wr_r    <= 1'b0;
      nack_r     <= 1'b0;
      rd_shift_r <= 8'd0;
    end else if (tick_s) begin
      if (state_r == IDLE) begin
        state_r   <= state_n_s;
        q_r       <= 2'd0;
        bit_cnt_r <= 3'd0;
        if (state_n_s == START_1) begin
          addr_r   <= byte_addr;
          data_r   <= wr_data;
          addr16_r <= addr_num;
          is_wr_r  <= wr_en;
          nack_r   <= 1'b0;
        end
      end else begin
        q_r <= q_r + 2'd1;
        if (q_r == 2'd2) begin
          if (is_ack_s && sda_in_s) nack_r <= 1'b1;
          if (state_r == RD_DATA) rd_shift_r <= {rd_shift_r[6:0], sda_in_s};
        end
        if (q_r == 2'd3) begin
          state_r   <= state_n_s;
          bit_cnt_r <= is_data_s ? bit_cnt_r + 3'd1 : 3'd0;
        end
      end
    end
  end

  // Registered bus drive and completion outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_r     <= 1'b1;
      sda_low_r <= 1'b0;
      i2c_end   <= 1'b0;
      ack_err   <= 1'b0;
      rd_data   <= 8'h00;
    end else begin
      scl_r     <= scl_s;
      sda_low_r <= sda_low_s;
      i2c_end   <= done_s;
      ack_err   <= done_s && nack_r;
      if (done_s && !is_wr_r && !nack_r) rd_data <= rd_shift_r;
    end
  end

endmodule
